// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode bundle: the fetch side pushes PC/instruction pairs, the decode
// side pops the head entry; status outputs ride along with the decode side.
interface fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_in;
    logic [ILEN-1:0] instr_in;
    logic            fetch_valid;
    logic            stall_fetch;
    logic            flush;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [ILEN-1:0] dec_instr;
    logic            dec_misaligned;
    logic [CW-1:0]   count;
    logic            overflow;

    modport slave (
        input  pc_in, instr_in, fetch_valid, flush, dec_ready,
        output stall_fetch, dec_valid, dec_pc, dec_instr, dec_misaligned, count, overflow
    );

    modport master (
        output pc_in, instr_in, fetch_valid, flush, dec_ready,
        input  stall_fetch, dec_valid, dec_pc, dec_instr, dec_misaligned, count, overflow
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small circular FIFO between instruction fetch and decode, with early stall,
// redirect flush and a sticky overflow flag for upstream protocol errors.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    fetch_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misaligned;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push, pop, full;

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        // Flush squashes both sides of the handshake in its cycle.
        pop        = (count_q != '0) && bus.dec_ready && !bus.flush;
        push       = bus.fetch_valid && !bus.flush && (!full || pop);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.fetch_valid && !bus.flush && full && !pop);

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: bus.pc_in, instr: bus.instr_in,
                                    misaligned: (bus.pc_in[1:0] != 2'b00)};
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Head is shown ahead; stall looks only at registered occupancy so decode
    // readiness never reaches the PC combinationally.
    assign bus.dec_valid      = (count_q != '0);
    assign bus.dec_pc         = mem_q[rd_ptr_q].pc;
    assign bus.dec_instr      = mem_q[rd_ptr_q].instr;
    assign bus.dec_misaligned = mem_q[rd_ptr_q].misaligned;
    assign bus.stall_fetch    = (count_q >= CW'(DEPTH - 1));
    assign bus.count          = count_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Consumer end of the fetch interface: accepts the PC/instruction pairs produced each cycle by the program counter and instruction memory.
- Queues them in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives stall_fetch back to the program counter when it cannot absorb further fetches.
- Discards all queued wrong-path instructions on a redirect flush.

Parameters:
DEPTH, 4, number of buffered entries; power of two, at least 2
XLEN, 32, PC width
ILEN, 32, instruction width

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state
pc_in  input  XLEN  PC of the instruction presented this cycle
instr_in  input  ILEN  instruction word fetched at pc_in
fetch_valid  input  1  pc_in/instr_in valid this cycle
stall_fetch  output  1  PC must hold; buffer cannot guarantee room
flush  input  1  branch/jump redirect; drop all entries and the same-cycle fetch
dec_valid  output  1  head entry valid for decode
dec_ready  input  1  decode accepts the head entry this cycle
dec_pc  output  XLEN  PC of head entry
dec_instr  output  ILEN  instruction of head entry
dec_misaligned  output  1  head entry PC has pc[1:0] != 0
count  output  $clog2(DEPTH)+1  occupied entries
overflow  output  1  sticky error: a valid fetch arrived with no free slot

Behaviour:
- Reset (synchronous, active-high, priority over all else):
  - Pointers and count go to 0; overflow goes to 0.
  - dec_valid=0, stall_fetch=0.
  - dec_pc and dec_instr read 0.
- Storage: circular FIFO with rd_ptr, wr_ptr (log2 DEPTH bits, natural wrap) and count.
  - Head is shown ahead: dec_pc, dec_instr and dec_misaligned are driven combinationally from the entry at rd_ptr.
  - dec_valid = (count != 0).
  - Entries hold pc, instr and misaligned flag (pc_in[1:0] != 0, captured at push).
- pop = dec_valid && dec_ready; rd_ptr advances on pop.
- push = fetch_valid && !flush && (count < DEPTH || pop); wr_ptr advances on push.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Full with pop in the same cycle: the push is accepted into the freed slot. No bypass, so the entry is visible no earlier than the next cycle.
- Overflow: fetch_valid && !flush && count == DEPTH && !pop.
  - Entry is dropped.
  - overflow sets and holds until reset; flush does not clear it.
- stall_fetch = (count >= DEPTH-1), combinational from registered count only.
  - No dependence on dec_ready, so there is no combinational path decode-to-PC.
  - The one free slot absorbs the fetch already in flight behind the PC register, so correct upstream never overflows.
- Flush (cycle N):
  - Any pop and push in cycle N are ignored, including a same-cycle fetch_valid.
  - Pointers and count are cleared at the end of cycle N.
  - dec_valid=0 in N+1, and stall_fetch=0 in N+1.
  - The first post-redirect fetch presented in N+1 is pushed normally.
  - Flush has no effect on overflow.
- dec_ready while dec_valid=0 is ignored.
- Head outputs must stay stable while dec_valid=1 and dec_ready=0.
- Order is strict FIFO; no entry is duplicated or reordered across wrap-around.

Test Plan:
- Reset then idle: after reset high 2 cycles, dec_valid=0, count=0, stall_fetch=0, overflow=0.
- Streaming: push pc 0x0,0x4,0x8,0xC with dec_ready=1 every cycle -> decode sees the same order one cycle after each push; count never exceeds 1; stall_fetch never asserts.
- Backpressure: dec_ready=0, push 0x100.. every cycle.
  - stall_fetch rises when count=3.
  - The in-flight 4th push is accepted (count=4).
  - No overflow; dec_pc holds at 0x100.
  - Releasing dec_ready drains 0x100,0x104,0x108,0x10C in order.
- Full with simultaneous push+pop: count=4, fetch_valid=1, dec_ready=1 -> count stays 4; pc 0x110 lands after 0x10C; overflow stays 0. Repeat 2*DEPTH cycles to cover pointer wrap.
- Flush: count=3 and fetch_valid=1 with flush=1 -> next cycle count=0, dec_valid=0. The next fetch of pc 0x200 appears at dec_pc=0x200 with no stale entries.
- Error paths:
  - Force fetch_valid=1 at count=4 with dec_ready=0 -> overflow=1, entry dropped, count=4; overflow remains 1 after a flush and clears only on reset.
  - Push pc 0x202 -> dec_misaligned=1 when it reaches the head.
